// File: rtl/id_stage.sv
// Decode stage of the five-stage RV32I pipeline: decode, register file, RAW interlock, flush.
// Optional macro ID_RF_BYPASS_EN forwards the WB write port into same-cycle register reads.
module id_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_to_id_valid,
  input  logic [63:0]  if_to_id_bus,
  input  logic [31:0]  irom_rdata,
  input  logic         ex_allow_in,
  input  logic         br_taken,
  input  logic [6:0]   ex_hint,
  input  logic [6:0]   mem_hint,
  input  logic         wb_rf_we,
  input  logic [4:0]   wb_rf_waddr,
  input  logic [31:0]  wb_rf_wdata,
  output logic         id_allow_in,
  output logic         id_to_ex_valid,
  output logic [150:0] id_to_ex_bus
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  // pc4 travels with the fetch bus but EX recomputes it, so ID drops it.
  logic [31:0] unused_pc4;
  assign unused_pc4 = if_to_id_bus[63:32];

  logic        id_valid_q, id_valid_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_buf_vld_q, inst_buf_vld_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic        hazard;
  logic        id_ready_go;
  logic [31:0] inst;

  assign inst           = inst_buf_vld_q ? inst_buf_q : irom_rdata;
  assign id_ready_go    = !hazard;
  assign id_allow_in    = !id_valid_q || (id_ready_go && ex_allow_in);
  assign id_to_ex_valid = id_valid_q && id_ready_go && !br_taken;

  // A stalled instruction keeps its IROM word in inst_buf, since rdata is only good once.
  always_comb begin
    id_valid_d     = id_valid_q;
    pc_d           = pc_q;
    inst_buf_vld_d = inst_buf_vld_q;
    inst_buf_d     = inst_buf_q;
    if (br_taken) begin
      id_valid_d     = 1'b0;
      inst_buf_vld_d = 1'b0;
    end else if (id_allow_in) begin
      id_valid_d     = if_to_id_valid;
      pc_d           = if_to_id_bus[31:0];
      inst_buf_vld_d = 1'b0;
    end else if (!inst_buf_vld_q) begin
      inst_buf_vld_d = 1'b1;
      inst_buf_d     = irom_rdata;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (wb_rf_we && (wb_rf_waddr != 5'd0)) begin
      rf_d[wb_rf_waddr] = wb_rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q     <= 1'b0;
      pc_q           <= '0;
      inst_buf_vld_q <= 1'b0;
      inst_buf_q     <= '0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      id_valid_q     <= id_valid_d;
      pc_q           <= pc_d;
      inst_buf_vld_q <= inst_buf_vld_d;
      inst_buf_q     <= inst_buf_d;
      rf_q           <= rf_d;
    end
  end

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'd0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                             input logic is_reg);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = (alt && is_reg) ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic [1:0]  src1_sel;
  logic        src2_sel;
  logic        rf_we_raw;
  logic        rf_we;
  logic        mem_re, mem_we;
  logic        is_branch, is_jal, is_jalr;
  logic [1:0]  wb_sel;
  logic        rs1_used, rs2_used;

  // Unrecognised opcodes fall through to the defaults and travel to EX as a bubble.
  always_comb begin
    imm       = '0;
    alu_op    = AluAdd;
    src1_sel  = 2'd0;
    src2_sel  = 1'b0;
    rf_we_raw = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    wb_sel    = 2'd0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    case (opcode)
      OpLui: begin
        imm       = imm_u;
        alu_op    = AluPassB;
        src1_sel  = 2'd2;
        src2_sel  = 1'b1;
        rf_we_raw = 1'b1;
      end
      OpAuipc: begin
        imm       = imm_u;
        src1_sel  = 2'd1;
        src2_sel  = 1'b1;
        rf_we_raw = 1'b1;
      end
      OpJal: begin
        imm       = imm_j;
        src1_sel  = 2'd1;
        src2_sel  = 1'b1;
        rf_we_raw = 1'b1;
        is_jal    = 1'b1;
        wb_sel    = 2'd2;
      end
      OpJalr: begin
        imm       = imm_i;
        src2_sel  = 1'b1;
        rf_we_raw = 1'b1;
        is_jalr   = 1'b1;
        wb_sel    = 2'd2;
        rs1_used  = 1'b1;
      end
      OpBranch: begin
        imm       = imm_b;
        alu_op    = AluSub;
        is_branch = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      OpLoad: begin
        imm       = imm_i;
        src2_sel  = 1'b1;
        rf_we_raw = 1'b1;
        mem_re    = 1'b1;
        wb_sel    = 2'd1;
        rs1_used  = 1'b1;
      end
      OpStore: begin
        imm       = imm_s;
        src2_sel  = 1'b1;
        mem_we    = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      OpImm: begin
        imm       = imm_i;
        alu_op    = alu_from_f3(funct3, inst[30], 1'b0);
        src2_sel  = 1'b1;
        rf_we_raw = 1'b1;
        rs1_used  = 1'b1;
      end
      OpReg: begin
        alu_op    = alu_from_f3(funct3, inst[30], 1'b1);
        rf_we_raw = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      default: ;
    endcase
  end

  assign rf_we = rf_we_raw && (rd != 5'd0);

  function automatic logic hint_hit(input logic [6:0] hint, input logic [4:0] rs);
    return hint[6] && hint[5] && (rs == hint[4:0]);
  endfunction

  logic rs1_hit, rs2_hit;

`ifdef ID_RF_BYPASS_EN
  assign rs1_hit = hint_hit(ex_hint, rs1) || hint_hit(mem_hint, rs1);
  assign rs2_hit = hint_hit(ex_hint, rs2) || hint_hit(mem_hint, rs2);
`else
  assign rs1_hit = hint_hit(ex_hint, rs1) || hint_hit(mem_hint, rs1) ||
                   hint_hit({1'b1, wb_rf_we, wb_rf_waddr}, rs1);
  assign rs2_hit = hint_hit(ex_hint, rs2) || hint_hit(mem_hint, rs2) ||
                   hint_hit({1'b1, wb_rf_we, wb_rf_waddr}, rs2);
`endif

  assign hazard = id_valid_q && ((rs1_used && (rs1 != 5'd0) && rs1_hit) ||
                                 (rs2_used && (rs2 != 5'd0) && rs2_hit));

  function automatic logic [31:0] rf_read(input logic [4:0] addr,
                                          input logic [31:0] rf_val,
                                          input logic wb_we, input logic [4:0] wb_addr,
                                          input logic [31:0] wb_data);
    logic [31:0] val;
    val = rf_val;
`ifdef ID_RF_BYPASS_EN
    if (wb_we && (wb_addr == addr)) begin
      val = wb_data;
    end
`else
    if (wb_we && (wb_addr == addr) && 1'b0) begin
      val = wb_data;
    end
`endif
    if (addr == 5'd0) begin
      val = '0;
    end
    return val;
  endfunction

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = rf_read(rs1, rf_q[rs1], wb_rf_we, wb_rf_waddr, wb_rf_wdata);
  assign rs2_val = rf_read(rs2, rf_q[rs2], wb_rf_we, wb_rf_waddr, wb_rf_wdata);

  assign id_to_ex_bus = {pc_q, imm, rs1_val, rs2_val, rd, rf_we, alu_op, src1_sel, src2_sel,
                         mem_re, mem_we, funct3, is_branch, is_jal, is_jalr, wb_sel};

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus a randomized stream against a decode model.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_to_id_valid;
  logic [63:0]  if_to_id_bus;
  logic [31:0]  irom_rdata;
  logic         ex_allow_in;
  logic         br_taken;
  logic [6:0]   ex_hint;
  logic [6:0]   mem_hint;
  logic         wb_rf_we;
  logic [4:0]   wb_rf_waddr;
  logic [31:0]  wb_rf_wdata;
  logic         id_allow_in;
  logic         id_to_ex_valid;
  logic [150:0] id_to_ex_bus;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_rf [32];

  id_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_to_id_valid(if_to_id_valid),
    .if_to_id_bus  (if_to_id_bus),
    .irom_rdata    (irom_rdata),
    .ex_allow_in   (ex_allow_in),
    .br_taken      (br_taken),
    .ex_hint       (ex_hint),
    .mem_hint      (mem_hint),
    .wb_rf_we      (wb_rf_we),
    .wb_rf_waddr   (wb_rf_waddr),
    .wb_rf_wdata   (wb_rf_wdata),
    .id_allow_in   (id_allow_in),
    .id_to_ex_valid(id_to_ex_valid),
    .id_to_ex_bus  (id_to_ex_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction from fetch, then the IROM word in its first ID cycle.
  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    if_to_id_valid = 1'b1;
    if_to_id_bus   = {pc + 32'd4, pc};
    step();
    if_to_id_valid = 1'b0;
    irom_rdata     = inst;
  endtask

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  // Expected bundle plus a mask of fields the instruction class leaves open.
  function automatic void model(input logic [31:0] inst, input logic [31:0] pc,
                                output logic [150:0] exp, output logic [150:0] msk);
    int imm;
    logic [3:0] alu;
    logic [1:0] s1, wb;
    logic s2, we, mr, mw, br, jl, jr;
    logic [3:0] m_alu;
    logic [1:0] m_s1;
    logic m_s2, m_rd;
    logic [31:0] m_imm, m_v1, m_v2;
    logic [2:0] m_f3;
    logic [6:0] op;
    op = inst[6:0];
    imm = 0; alu = 0; s1 = 0; s2 = 0; we = 0; mr = 0; mw = 0; br = 0; jl = 0; jr = 0; wb = 0;
    m_alu = 4'hF; m_s1 = 2'b11; m_s2 = 1'b1; m_rd = 1'b1; m_imm = '1; m_f3 = 3'b111;
    m_v1 = uses_rs1(op) ? '1 : '0;
    m_v2 = uses_rs2(op) ? '1 : '0;
    case (op)
      7'h37: begin imm = int'(inst & 32'hFFFFF000); alu = 10; s2 = 1; we = 1; m_s1 = 0;
                   m_f3 = 0; end
      7'h17: begin imm = int'(inst & 32'hFFFFF000); s1 = 1; s2 = 1; we = 1; m_f3 = 0; end
      7'h6F: begin
        imm = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048
              + int'(inst[30:21]) * 2;
        we = 1; jl = 1; wb = 2; m_alu = 0; m_s1 = 0; m_s2 = 0; m_f3 = 0;
      end
      7'h67: begin imm = int'($signed(inst) >>> 20); we = 1; jr = 1; wb = 2;
                   m_alu = 0; m_s1 = 0; m_s2 = 0; end
      7'h63: begin
        imm = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32
              + int'(inst[11:8]) * 2;
        br = 1; m_alu = 0; m_s1 = 0; m_s2 = 0; m_rd = 0;
      end
      7'h03: begin imm = int'($signed(inst) >>> 20); s2 = 1; we = 1; mr = 1; wb = 1; end
      7'h23: begin
        imm = int'($signed(inst) >>> 25) * 32 + int'(inst[11:7]);
        s2 = 1; mw = 1; m_rd = 0;
      end
      7'h13, 7'h33: begin
        if (op == 7'h13) begin imm = int'($signed(inst) >>> 20); s2 = 1; end
        else m_imm = 0;
        we = 1;
        case (inst[14:12])
          0: alu = (op == 7'h33 && inst[30]) ? 4'd1 : 4'd0;
          1: alu = 2;
          2: alu = 3;
          3: alu = 4;
          4: alu = 5;
          5: alu = inst[30] ? 4'd7 : 4'd6;
          6: alu = 8;
          default: alu = 9;
        endcase
      end
      default: ;
    endcase
    if (inst[11:7] == 0) we = 0;
    exp = {pc, 32'(imm), ref_rf[inst[19:15]], ref_rf[inst[24:20]], inst[11:7], we, alu, s1, s2,
           mr, mw, inst[14:12], br, jl, jr, wb};
    msk = {32'hFFFFFFFF, m_imm, m_v1, m_v2, {5{m_rd}}, 1'b1, m_alu, m_s1, m_s2, 1'b1, 1'b1,
           m_f3, 1'b1, 1'b1, 1'b1, 2'b11};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (id_allow_in !== 1'b1) begin errors++;
      $display("FAIL reset_allow_in: got %b want 1", id_allow_in); end
    checks++; if (id_to_ex_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", id_to_ex_valid); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_addi();
    load(32'd0, 32'h00500093);
    @(negedge clk);
    checks++; if (id_to_ex_valid !== 1'b1) begin errors++;
      $display("FAIL addi_valid: got %b want 1", id_to_ex_valid); end
    checks++; if ({id_to_ex_bus[22:18], id_to_ex_bus[17]} !== {5'd1, 1'b1}) begin errors++;
      $display("FAIL addi_rd_we: got %h want 03", {id_to_ex_bus[22:18], id_to_ex_bus[17]}); end
    checks++; if (id_to_ex_bus[118:87] !== 32'd5) begin errors++;
      $display("FAIL addi_imm: got %h want 5", id_to_ex_bus[118:87]); end
    checks++; if ({id_to_ex_bus[16:13], id_to_ex_bus[10]} !== 5'b00001) begin errors++;
      $display("FAIL addi_alu_src2: got %b want 00001", {id_to_ex_bus[16:13], id_to_ex_bus[10]});
    end
    checks++; if (id_to_ex_bus[150:119] !== 32'd0) begin errors++;
      $display("FAIL addi_pc: got %h want 0", id_to_ex_bus[150:119]); end
    step();
  endtask

  task automatic test_hazard_stall();
    load(32'h8, 32'h002081B3);
    ex_hint = 7'b1100001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({id_to_ex_valid, id_allow_in} !== 2'b00) begin errors++;
        $display("FAIL stall_cycle%0d: got %b want 00", c, {id_to_ex_valid, id_allow_in}); end
      step();
      irom_rdata = 32'hFFFFFFFF;
    end
    ex_hint = '0;
    @(negedge clk);
    checks++; if (id_to_ex_valid !== 1'b1) begin errors++;
      $display("FAIL stall_issue_valid: got %b want 1", id_to_ex_valid); end
    checks++; if ({id_to_ex_bus[22:18], id_to_ex_bus[16:13], id_to_ex_bus[10]} !== 10'b00011_0000_0)
    begin errors++;
      $display("FAIL stall_issue_fields: got %b want 0001100000",
               {id_to_ex_bus[22:18], id_to_ex_bus[16:13], id_to_ex_bus[10]});
    end
    step();
  endtask

  task automatic test_wb_read();
    load(32'h10, 32'h00028313);
    wb_rf_we = 1'b1; wb_rf_waddr = 5'd5; wb_rf_wdata = 32'hDEADBEEF;
    @(negedge clk);
`ifdef ID_RF_BYPASS_EN
    checks++; if ({id_to_ex_valid, id_to_ex_bus[86:55]} !== {1'b1, 32'hDEADBEEF}) begin errors++;
      $display("FAIL wb_bypass: got %b/%h want 1/deadbeef", id_to_ex_valid, id_to_ex_bus[86:55]);
    end
`else
    checks++; if (id_to_ex_valid !== 1'b0) begin errors++;
      $display("FAIL wb_stall: got %b want 0", id_to_ex_valid); end
    step();
    wb_rf_we = 1'b0;
    irom_rdata = 32'h0;
    @(negedge clk);
    checks++; if ({id_to_ex_valid, id_to_ex_bus[86:55]} !== {1'b1, 32'hDEADBEEF}) begin errors++;
      $display("FAIL wb_after_stall: got %b/%h want 1/deadbeef", id_to_ex_valid,
               id_to_ex_bus[86:55]);
    end
`endif
    step();
    wb_rf_we = 1'b0;
  endtask

  task automatic test_branch_flush();
    load(32'h20, 32'h00000063);
    br_taken = 1'b1;
    if_to_id_valid = 1'b1; if_to_id_bus = {32'h28, 32'h24};
    @(negedge clk);
    checks++; if (id_to_ex_valid !== 1'b0) begin errors++;
      $display("FAIL flush_same_cycle: got %b want 0", id_to_ex_valid); end
    step();
    br_taken = 1'b0; if_to_id_valid = 1'b0; irom_rdata = 32'h00500093;
    @(negedge clk);
    checks++; if ({id_to_ex_valid, id_allow_in} !== 2'b01) begin errors++;
      $display("FAIL flush_next: got %b want 01", {id_to_ex_valid, id_allow_in}); end
    // Flush arriving during a RAW stall
    load(32'h30, 32'h002081B3);
    mem_hint = 7'b1100010;
    @(negedge clk);
    checks++; if (id_to_ex_valid !== 1'b0) begin errors++;
      $display("FAIL flush_stall_pre: got %b want 0", id_to_ex_valid); end
    step();
    br_taken = 1'b1;
    step();
    br_taken = 1'b0;
    @(negedge clk);
    checks++; if ({id_to_ex_valid, id_allow_in} !== 2'b01) begin errors++;
      $display("FAIL flush_stall_post: got %b want 01", {id_to_ex_valid, id_allow_in}); end
    mem_hint = '0;
    step();
  endtask

  task automatic test_backpressure();
    load(32'h40, 32'h123453B7);
    ex_allow_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if ({id_to_ex_valid, id_allow_in} !== 2'b10) begin errors++;
        $display("FAIL bp_handshake%0d: got %b want 10", c, {id_to_ex_valid, id_allow_in}); end
      checks++; if ({id_to_ex_bus[150:119], id_to_ex_bus[118:87], id_to_ex_bus[22:18],
                     id_to_ex_bus[16:13]} !== {32'h40, 32'h12345000, 5'd7, 4'd10}) begin
        errors++;
        $display("FAIL bp_bundle%0d: got pc %h imm %h rd %0d alu %0d want 40 12345000 7 10", c,
                 id_to_ex_bus[150:119], id_to_ex_bus[118:87], id_to_ex_bus[22:18],
                 id_to_ex_bus[16:13]);
      end
      step();
      irom_rdata = $urandom;
    end
    ex_allow_in = 1'b1;
    @(negedge clk);
    checks++; if (id_allow_in !== 1'b1) begin errors++;
      $display("FAIL bp_release: got %b want 1", id_allow_in); end
    step();
  endtask

  task automatic test_illegal();
    load(32'h50, 32'h00000FFF);
    @(negedge clk);
    checks++; if (id_to_ex_valid !== 1'b1) begin errors++;
      $display("FAIL illegal_valid: got %b want 1", id_to_ex_valid); end
    checks++; if ({id_to_ex_bus[17], id_to_ex_bus[9:8], id_to_ex_bus[4:2]} !== 6'b0) begin
      errors++;
      $display("FAIL illegal_ctrl: got %b want 000000",
               {id_to_ex_bus[17], id_to_ex_bus[9:8], id_to_ex_bus[4:2]});
    end
    step();
  endtask

  task automatic test_reset_mid_stall();
    load(32'h60, 32'h002081B3);
    ex_hint = 7'b1100010;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({id_to_ex_valid, id_allow_in} !== 2'b01) begin errors++;
      $display("FAIL reset_mid_stall: got %b want 01", {id_to_ex_valid, id_allow_in}); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({id_to_ex_valid, id_allow_in} !== 2'b01) begin errors++;
      $display("FAIL reset_release: got %b want 01", {id_to_ex_valid, id_allow_in}); end
    ex_hint = '0;
    step();
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    logic [31:0] inst, pc, wd;
    logic [4:0] wa, r;
    logic [6:0] eh, mh;
    logic [150:0] exp, msk;
    logic h, exp_v, issued;
    int stall_n, bp_n;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    step();
    for (int it = 0; it < 200; it++) begin
      inst = {$urandom} & 32'hFFFFFF80 | {25'd0, ops[$urandom_range(0, 8)]};
      pc   = {$urandom} & 32'hFFFFFFFC;
      wa = 5'($urandom_range(0, 31)); wd = $urandom;
      wb_rf_we = 1'b1; wb_rf_waddr = wa; wb_rf_wdata = wd;
      step();
      if (wa != 0) ref_rf[wa] = wd;
      wb_rf_we = 1'b0;
      load(pc, inst);
      r  = ($urandom_range(0, 1) != 0) ? inst[19:15] : inst[24:20];
      eh = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0) ? r : 5'($urandom)};
      r  = ($urandom_range(0, 1) != 0) ? inst[19:15] : inst[24:20];
      mh = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0) ? r : 5'($urandom)};
      stall_n = $urandom_range(0, 2);
      bp_n    = $urandom_range(0, 2);
      h = 1'b0;
      for (int s = 0; s < 2; s++) begin
        r = (s == 0) ? inst[19:15] : inst[24:20];
        if (((s == 0) ? uses_rs1(inst[6:0]) : uses_rs2(inst[6:0])) && r != 0 &&
            ((eh[6] && eh[5] && eh[4:0] == r) || (mh[6] && mh[5] && mh[4:0] == r)))
          h = 1'b1;
      end
      model(inst, pc, exp, msk);
      issued = 1'b0;
      for (int k = 0; k < 6 && !issued; k++) begin
        ex_hint     = (k < stall_n) ? eh : 7'd0;
        mem_hint    = (k < stall_n) ? mh : 7'd0;
        ex_allow_in = (k >= bp_n);
        @(negedge clk);
        exp_v = !(h && k < stall_n);
        checks++; if (id_to_ex_valid !== exp_v) begin errors++;
          $display("FAIL rnd_valid it%0d k%0d inst %h: got %b want %b", it, k, inst,
                   id_to_ex_valid, exp_v); end
        checks++; if (id_allow_in !== (exp_v && ex_allow_in)) begin errors++;
          $display("FAIL rnd_allow it%0d k%0d: got %b want %b", it, k, id_allow_in,
                   exp_v && ex_allow_in); end
        if (exp_v) begin
          checks++; if ((id_to_ex_bus & msk) !== (exp & msk)) begin errors++;
            $display("FAIL rnd_bundle it%0d k%0d inst %h: got %h want %h", it, k, inst,
                     id_to_ex_bus & msk, exp & msk); end
        end
        issued = exp_v && ex_allow_in;
        step();
        irom_rdata = $urandom;
      end
      ex_hint = '0; mem_hint = '0; ex_allow_in = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; if_to_id_valid = 1'b0; if_to_id_bus = '0; irom_rdata = '0;
    ex_allow_in = 1'b1; br_taken = 1'b0; ex_hint = '0; mem_hint = '0;
    wb_rf_we = 1'b0; wb_rf_waddr = '0; wb_rf_wdata = '0;
    #2;
    test_reset();
    test_addi();
    test_hazard_stall();
    test_wb_read();
    test_branch_flush();
    test_backpressure();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
